// File: rtl/pipeline_pkg.sv
// Shared pixel types and constants for the video compositing pipeline.
package pipeline_pkg;

  localparam int unsigned PIXEL_W = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // RGB565 green field position; used to build and inspect key colours.
  localparam int unsigned GREEN_MSB = 10;
  localparam int unsigned GREEN_LSB = 5;
  localparam int unsigned GREEN_W   = GREEN_MSB - GREEN_LSB + 1;

  // Full green, no red or blue: the chroma keyer treats this as transparent.
  localparam pixel_t KEY_GREEN_FILL = 16'h07E0;

  function automatic logic [GREEN_W-1:0] green_of(input pixel_t p);
    return p[GREEN_MSB:GREEN_LSB];
  endfunction

endpackage

// File: rtl/pipeline_fifo.sv
// Power-of-two FIFO with push/pop/flush and an occupancy count, no bypass path.
module pipeline_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             push_ok, pop_ok;

  // Guards keep the level inside 0..DEPTH even if a caller misbehaves.
  always_comb begin
    push_ok  = push & ~flush & (level_q != LW'(DEPTH));
    pop_ok   = pop  & ~flush & (level_q != LW'(0));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LW'(0);
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; the level decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign level   = level_q;

endmodule

// File: rtl/pipeline_fg_align.sv
// Aligns buffered foreground pixels to the background stream, filling with key green on underflow.
// Optional: define FG_UNDERFLOW_COUNT_EN to add a saturating per-frame underflow_count output.
module pipeline_fg_align
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter pixel_t      FILL_PIXEL = KEY_GREEN_FILL,
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          bg_valid,
  input  logic [15:0]   bg_pixel_in,
  input  logic          fg_valid,
  input  logic [15:0]   fg_pixel_in,
  output logic          fg_ready,
  output logic          pixel_valid,
  output logic [15:0]   bg_pixel_out,
  output logic [15:0]   fg_pixel_out,
  output logic          underflow,
  output logic [LW-1:0] fifo_level
`ifdef FG_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]   underflow_count
`endif
);

  pixel_t        rd_data;
  logic [LW-1:0] level;
  logic          push_c, pop_c, underflow_c;

  logic   pixel_valid_q, pixel_valid_d;
  pixel_t bg_pixel_q,    bg_pixel_d;
  pixel_t fg_pixel_q,    fg_pixel_d;
  logic   underflow_q,   underflow_d;

  pipeline_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIXEL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .wr_data (fg_pixel_in),
    .pop     (pop_c),
    .flush   (frame_start),
    .rd_data (rd_data),
    .level   (level)
  );

  assign fg_ready   = (level != LW'(DEPTH));
  assign fifo_level = level;

  // frame_start wins: no push, no pop, and any bg pixel this cycle gets the fill.
  always_comb begin
    push_c        = fg_valid & fg_ready & ~frame_start;
    pop_c         = bg_valid & ~frame_start & (level != LW'(0));
    underflow_c   = bg_valid & ~pop_c;
    pixel_valid_d = bg_valid;
    underflow_d   = underflow_c;
    bg_pixel_d    = bg_pixel_q;
    fg_pixel_d    = fg_pixel_q;
    if (bg_valid) begin
      bg_pixel_d = bg_pixel_in;
      fg_pixel_d = pop_c ? rd_data : FILL_PIXEL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid_q <= 1'b0;
      bg_pixel_q    <= '0;
      fg_pixel_q    <= FILL_PIXEL;
      underflow_q   <= 1'b0;
    end else begin
      pixel_valid_q <= pixel_valid_d;
      bg_pixel_q    <= bg_pixel_d;
      fg_pixel_q    <= fg_pixel_d;
      underflow_q   <= underflow_d;
    end
  end

  assign pixel_valid  = pixel_valid_q;
  assign bg_pixel_out = bg_pixel_q;
  assign fg_pixel_out = fg_pixel_q;
  assign underflow    = underflow_q;

`ifdef FG_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // An underflow in the frame_start cycle belongs to the new frame.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (frame_start) begin
      uf_cnt_d = underflow_c ? 16'd1 : 16'd0;
    end else if (underflow_c && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) uf_cnt_q <= 16'd0;
    else     uf_cnt_q <= uf_cnt_d;
  end

  assign underflow_count = uf_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_fg_align.sv
// Directed bench for pipeline_fg_align with hand-computed expected outputs.
module tb_pipeline_fg_align;

  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          bg_valid;
  logic [15:0]   bg_pixel_in;
  logic          fg_valid;
  logic [15:0]   fg_pixel_in;
  logic          fg_ready;
  logic          pixel_valid;
  logic [15:0]   bg_pixel_out;
  logic [15:0]   fg_pixel_out;
  logic          underflow;
  logic [LW-1:0] fifo_level;
`ifdef FG_UNDERFLOW_COUNT_EN
  logic [15:0]   underflow_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_fg_align #(.DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .bg_valid     (bg_valid),
    .bg_pixel_in  (bg_pixel_in),
    .fg_valid     (fg_valid),
    .fg_pixel_in  (fg_pixel_in),
    .fg_ready     (fg_ready),
    .pixel_valid  (pixel_valid),
    .bg_pixel_out (bg_pixel_out),
    .fg_pixel_out (fg_pixel_out),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
`ifdef FG_UNDERFLOW_COUNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0;
    bg_valid    = 1'b0;
    fg_valid    = 1'b0;
  endtask

  task automatic push_word(input logic [15:0] d);
    idle();
    fg_valid    = 1'b1;
    fg_pixel_in = d;
    tick();
    fg_valid    = 1'b0;
  endtask

  task automatic bg_only(input logic [15:0] b);
    idle();
    bg_valid    = 1'b1;
    bg_pixel_in = b;
    tick();
    bg_valid    = 1'b0;
  endtask

  task automatic check_pair(input string tag, input logic [15:0] b, input logic [15:0] f,
                            input logic uf);
    check({tag, ".valid"}, 32'(pixel_valid), 32'd1);
    check({tag, ".bg"},    32'(bg_pixel_out), 32'(b));
    check({tag, ".fg"},    32'(fg_pixel_out), 32'(f));
    check({tag, ".uf"},    32'(underflow), 32'(uf));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bg_pixel_in = 16'h0;
    fg_pixel_in = 16'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    check("rst.valid", 32'(pixel_valid), 32'd0);
    check("rst.bg",    32'(bg_pixel_out), 32'h0);
    check("rst.fg",    32'(fg_pixel_out), 32'h07E0);
    check("rst.uf",    32'(underflow), 32'd0);
    check("rst.level", 32'(fifo_level), 32'd0);
    check("rst.ready", 32'(fg_ready), 32'd1);

    // Fill to DEPTH, then a 17th offer must be refused.
    for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i));
    check("fill.level", 32'(fifo_level), 32'd16);
    check("fill.ready", 32'(fg_ready), 32'd0);
    push_word(16'hDEAD);
    check("fill.17th.level", 32'(fifo_level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      bg_only(16'hAAAA);
      check_pair("drain", 16'hAAAA, 16'h0100 + 16'(i), 1'b0);
    end
    check("drain.level", 32'(fifo_level), 32'd0);
    bg_only(16'hAAAB);
    check_pair("drain.after", 16'hAAAB, 16'h07E0, 1'b1);

    // Reset in the middle of a stream.
    push_word(16'h0031);
    push_word(16'h0032);
    push_word(16'h0033);
    bg_only(16'h5555);
    check_pair("pre_rst", 16'h5555, 16'h0031, 1'b0);
    bg_valid    = 1'b1;
    fg_valid    = 1'b1;
    fg_pixel_in = 16'h0034;
    rst = 1'b1;
    tick();
    check("mid_rst.valid", 32'(pixel_valid), 32'd0);
    check("mid_rst.fg",    32'(fg_pixel_out), 32'h07E0);
    check("mid_rst.level", 32'(fifo_level), 32'd0);
    check("mid_rst.ready", 32'(fg_ready), 32'd1);
    idle();
    rst = 1'b0;
    tick();

    // Aligned flow with a hold cycle after.
    for (int i = 1; i <= 4; i++) push_word(16'(i));
    check("flow.level", 32'(fifo_level), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      bg_only(16'hF800);
      check_pair("flow", 16'hF800, 16'(i), 1'b0);
    end
    idle();
    tick();
    check("hold.valid", 32'(pixel_valid), 32'd0);
    check("hold.fg",    32'(fg_pixel_out), 32'h0004);
    check("hold.bg",    32'(bg_pixel_out), 32'hF800);

    // Underflow with a simultaneous push: no bypass.
    bg_valid    = 1'b1;
    bg_pixel_in = 16'h1111;
    fg_valid    = 1'b1;
    fg_pixel_in = 16'h1234;
    tick();
    check_pair("uf", 16'h1111, 16'h07E0, 1'b1);
    check("uf.level", 32'(fifo_level), 32'd1);
    bg_only(16'h2222);
    check_pair("uf.next", 16'h2222, 16'h1234, 1'b0);
    check("uf.next.level", 32'(fifo_level), 32'd0);

    // Simultaneous push and pop keeps the level.
    push_word(16'h0021);
    push_word(16'h0022);
    bg_valid    = 1'b1;
    bg_pixel_in = 16'h3333;
    fg_valid    = 1'b1;
    fg_pixel_in = 16'h0023;
    tick();
    check_pair("pp", 16'h3333, 16'h0021, 1'b0);
    check("pp.level", 32'(fifo_level), 32'd2);
    bg_only(16'h3334);
    check_pair("pp.d1", 16'h3334, 16'h0022, 1'b0);
    bg_only(16'h3335);
    check_pair("pp.d2", 16'h3335, 16'h0023, 1'b0);

    // frame_start flushes and drops the concurrent push.
    for (int i = 0; i < 5; i++) push_word(16'h0050 + 16'(i));
    check("fs.pre.level", 32'(fifo_level), 32'd5);
    idle();
    frame_start = 1'b1;
    fg_valid    = 1'b1;
    fg_pixel_in = 16'h0099;
    tick();
    check("fs.level", 32'(fifo_level), 32'd0);
    check("fs.valid", 32'(pixel_valid), 32'd0);
    bg_only(16'h4444);
    check_pair("fs.after", 16'h4444, 16'h07E0, 1'b1);

    // frame_start with bg_valid: forced underflow.
    push_word(16'h0061);
    push_word(16'h0062);
    idle();
    frame_start = 1'b1;
    bg_valid    = 1'b1;
    bg_pixel_in = 16'h4545;
    tick();
    check_pair("fs_bg", 16'h4545, 16'h07E0, 1'b1);
    check("fs_bg.level", 32'(fifo_level), 32'd0);
    idle();
    tick();
    check("fs_bg.uf_clear", 32'(underflow), 32'd0);

`ifdef FG_UNDERFLOW_COUNT_EN
    idle();
    frame_start = 1'b1;
    tick();
    check("cnt.fs", 32'(underflow_count), 32'd0);
    for (int i = 0; i < 3; i++) bg_only(16'h0E0E);
    check("cnt.three", 32'(underflow_count), 32'd3);
    idle();
    frame_start = 1'b1;
    tick();
    check("cnt.clear", 32'(underflow_count), 32'd0);
    idle();
    bg_valid    = 1'b1;
    bg_pixel_in = 16'h0F0F;
    for (int i = 0; i < 70000; i++) tick();
    check("cnt.sat", 32'(underflow_count), 32'hFFFF);
    idle();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
